text_console: RTL and testbench

TEXT_CONSOLE -- requirements
Module: text_console

---
 rtl/text_console.sv | 224 ++++++++++++++++++++++
 tb/tb_text_console.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
//   Character-stream console that turns CPU character codes into tile writes
//   for the text tile layer (TXBL, 30 rows x 32 columns at 12'h900).
//   Printable codes (0x20-0x7E) are written at the cursor and advance it.
//   LF, CR and BS move the cursor. BS also blanks the cell it moves onto.
//   Every other code is consumed silently.
//
//   Optional feature, macro TEXT_CONSOLE_CLEAR_EN:
//     defined   -> 0x0C clears the whole screen (960 space tiles), and a
//                  cursor row wrap from 29 to 0 blanks the new row.
//     undefined -> neither clearing path exists; 0x0C is ignored.
//
// Ports
//   cpu_clk         in   sole clock, rising edge
//   rst             in   asynchronous active-high reset
//   char_i          in   [7:0] character code
//   char_valid_i    in   char_i valid
//   char_ready_o    out  console can accept a character (IDLE only)
//   color_i         in   colorselect bit stored with printable characters
//   bus_grant_i     in   VRAM write slot granted this cycle
//   vram_wdata_o    out  [7:0]  tile data {colorselect, pmca[6:0]}
//   vram_address_o  out  [11:0] 12'h900 + {row, col}
//   vram_wen_o      out  write strobe, held until granted
//   SELECT_txbl_o   out  TXBL select, mirrors vram_wen_o
//   cursor_row_o    out  [4:0] cursor row (0-29)
//   cursor_col_o    out  [4:0] cursor column (0-31)
//   busy_o          out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module text_console (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    input  logic        color_i,
    input  logic        bus_grant_i,
    output logic [7:0]  vram_wdata_o,
    output logic [11:0] vram_address_o,
    output logic        vram_wen_o,
    output logic        SELECT_txbl_o,
    output logic [4:0]  cursor_row_o,
    output logic [4:0]  cursor_col_o,
    output logic        busy_o
);

    localparam logic [11:0] TXBL_BASE = 12'h900;
    localparam logic [7:0]  SPACE     = 8'h20;
    localparam logic [4:0]  LAST_ROW  = 5'd29;
    localparam logic [4:0]  LAST_COL  = 5'd31;

    typedef enum logic [1:0] {IDLE, WRITE, ROWCLR, CLEAR} state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_row, w_row_next;
    logic [4:0]  r_col, w_col_next;
    logic [11:0] r_addr, w_addr_next;
    logic [7:0]  r_wdata, w_wdata_next;
    logic        r_wen, w_wen_next;
    logic        r_noadv, w_noadv_next;   // set for the BS blanking write
`ifdef TEXT_CONSOLE_CLEAR_EN
    logic [9:0]  r_cnt, w_cnt_next;       // writes completed in ROWCLR/CLEAR
    logic        w_row_wrap;
`endif
    logic        w_accept;
    logic [4:0]  w_row_inc;

    function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [4:0] col);
        return TXBL_BASE + {2'b00, row, col};
    endfunction

    assign char_ready_o   = (r_state == IDLE) && !rst;
    assign w_accept       = char_valid_i && char_ready_o;
    assign w_row_inc      = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
`ifdef TEXT_CONSOLE_CLEAR_EN
    assign w_row_wrap     = (r_row == LAST_ROW);
`endif

    assign vram_wdata_o   = r_wdata;
    assign vram_address_o = r_addr;
    assign vram_wen_o     = r_wen;
    assign SELECT_txbl_o  = r_wen;
    assign cursor_row_o   = r_row;
    assign cursor_col_o   = r_col;
    assign busy_o         = (r_state != IDLE);

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_wen_next   = r_wen;
        w_noadv_next = r_noadv;
`ifdef TEXT_CONSOLE_CLEAR_EN
        w_cnt_next   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (char_i >= 8'h20 && char_i <= 8'h7E) begin
                        w_state_next = WRITE;
                        w_addr_next  = cell_addr(r_row, r_col);
                        w_wdata_next = {color_i, char_i[6:0]};
                        w_wen_next   = 1'b1;
                        w_noadv_next = 1'b0;
                    end else if (char_i == 8'h0A) begin
                        w_col_next = 5'd0;
                        w_row_next = w_row_inc;
`ifdef TEXT_CONSOLE_CLEAR_EN
                        if (w_row_wrap) begin
                            w_state_next = ROWCLR;
                            w_addr_next  = cell_addr(w_row_inc, 5'd0);
                            w_wdata_next = SPACE;
                            w_wen_next   = 1'b1;
                            w_cnt_next   = 10'd0;
                        end
`endif
                    end else if (char_i == 8'h0D) begin
                        w_col_next = 5'd0;
                    end else if (char_i == 8'h08) begin
                        // Backspace moves left, then blanks the cell it lands on.
                        if (r_col != 5'd0) begin
                            w_col_next   = r_col - 5'd1;
                            w_state_next = WRITE;
                            w_addr_next  = cell_addr(r_row, r_col - 5'd1);
                            w_wdata_next = SPACE;
                            w_wen_next   = 1'b1;
                            w_noadv_next = 1'b1;
                        end
`ifdef TEXT_CONSOLE_CLEAR_EN
                    end else if (char_i == 8'h0C) begin
                        w_state_next = CLEAR;
                        w_addr_next  = TXBL_BASE;
                        w_wdata_next = SPACE;
                        w_wen_next   = 1'b1;
                        w_cnt_next   = 10'd0;
`endif
                    end
                end
            end
            WRITE: begin
                if (bus_grant_i) begin
                    w_state_next = IDLE;
                    w_wen_next   = 1'b0;
                    if (!r_noadv) begin
                        if (r_col == LAST_COL) begin
                            w_col_next = 5'd0;
                            w_row_next = w_row_inc;
`ifdef TEXT_CONSOLE_CLEAR_EN
                            if (w_row_wrap) begin
                                w_state_next = ROWCLR;
                                w_addr_next  = cell_addr(w_row_inc, 5'd0);
                                w_wdata_next = SPACE;
                                w_wen_next   = 1'b1;
                                w_cnt_next   = 10'd0;
                            end
`endif
                        end else begin
                            w_col_next = r_col + 5'd1;
                        end
                    end
                end
            end
`ifdef TEXT_CONSOLE_CLEAR_EN
            ROWCLR: begin
                if (bus_grant_i) begin
                    if (r_cnt[4:0] == LAST_COL) begin
                        w_state_next = IDLE;
                        w_wen_next   = 1'b0;
                    end else begin
                        w_cnt_next  = r_cnt + 10'd1;
                        w_addr_next = r_addr + 12'd1;
                    end
                end
            end
            CLEAR: begin
                if (bus_grant_i) begin
                    if (r_cnt == 10'd959) begin
                        w_state_next = IDLE;
                        w_wen_next   = 1'b0;
                        w_row_next   = 5'd0;
                        w_col_next   = 5'd0;
                    end else begin
                        w_cnt_next  = r_cnt + 10'd1;
                        w_addr_next = r_addr + 12'd1;
                    end
                end
            end
`endif
            default: begin
                w_state_next = IDLE;
                w_wen_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= 5'd0;
            r_col   <= 5'd0;
            r_addr  <= TXBL_BASE;
            r_wdata <= 8'h00;
            r_wen   <= 1'b0;
            r_noadv <= 1'b0;
`ifdef TEXT_CONSOLE_CLEAR_EN
            r_cnt   <= 10'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_wen   <= w_wen_next;
            r_noadv <= w_noadv_next;
`ifdef TEXT_CONSOLE_CLEAR_EN
            r_cnt   <= w_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_text_console.sv
// -----------------------------------------------------------------------------
// tb_text_console
//   Directed and randomized character streams for text_console. A screen-level
//   reference model (cursor as row/column integers, expected tile writes as a
//   queue) predicts every VRAM write and the final cursor for each character.
//   Follows TEXT_CONSOLE_CLEAR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_text_console;

`ifdef TEXT_CONSOLE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        cpu_clk;
    logic        rst;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic        color_i;
    logic        bus_grant_i;
    logic [7:0]  vram_wdata_o;
    logic [11:0] vram_address_o;
    logic        vram_wen_o;
    logic        SELECT_txbl_o;
    logic [4:0]  cursor_row_o;
    logic [4:0]  cursor_col_o;
    logic        busy_o;

    text_console dut (
        .cpu_clk        (cpu_clk),
        .rst            (rst),
        .char_i         (char_i),
        .char_valid_i   (char_valid_i),
        .char_ready_o   (char_ready_o),
        .color_i        (color_i),
        .bus_grant_i    (bus_grant_i),
        .vram_wdata_o   (vram_wdata_o),
        .vram_address_o (vram_address_o),
        .vram_wen_o     (vram_wen_o),
        .SELECT_txbl_o  (SELECT_txbl_o),
        .cursor_row_o   (cursor_row_o),
        .cursor_col_o   (cursor_col_o),
        .busy_o         (busy_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Grant control: random when grant_rand, else high outside [stall_lo, stall_hi).
    bit grant_rand = 1'b0;
    int stall_lo = 0;
    int stall_hi = 0;
    int ncyc = 0;

    // Observed writes and strobe statistics (monitor-owned).
    logic [19:0] act_q[$];
    int wen_cycles = 0;
    int sel_bad = 0;
    int bound_bad = 0;

    // Reference model state.
    logic [19:0] exp_q[$];
    int m_row = 0;
    int m_col = 0;

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    initial begin
        bus_grant_i = 1'b0;
        forever begin
            @(negedge cpu_clk);
            ncyc++;
            if (grant_rand) bus_grant_i = ($urandom_range(0, 99) < 60);
            else            bus_grant_i = !(ncyc >= stall_lo && ncyc < stall_hi);
        end
    end

    always @(posedge cpu_clk) begin
        if (!rst) begin
            if (vram_wen_o) wen_cycles++;
            if (vram_wen_o && bus_grant_i) act_q.push_back({vram_address_o, vram_wdata_o});
            if (SELECT_txbl_o !== vram_wen_o) sel_bad++;
            if (cursor_row_o > 5'd29) bound_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic void m_put(input int r, input int c, input logic [7:0] d);
        exp_q.push_back({12'(12'h900 + r * 32 + c), d});
    endfunction

    function automatic void m_next_row();
        m_row++;
        if (m_row == 30) begin
            m_row = 0;
            if (CLR) for (int c = 0; c < 32; c++) m_put(0, c, 8'h20);
        end
    endfunction

    function automatic void model_char(input logic [7:0] c, input logic color);
        if (c >= 8'h20 && c <= 8'h7E) begin
            m_put(m_row, m_col, {color, c[6:0]});
            m_col++;
            if (m_col == 32) begin
                m_col = 0;
                m_next_row();
            end
        end else if (c == 8'h0A) begin
            m_col = 0;
            m_next_row();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_put(m_row, m_col, 8'h20);
            end
        end else if (c == 8'h0C && CLR) begin
            for (int a = 0; a < 960; a++) exp_q.push_back({12'(12'h900 + a), 8'h20});
            m_row = 0;
            m_col = 0;
        end
    endfunction

    task automatic send_char(input logic [7:0] c, input logic color);
        int guard;
        @(negedge cpu_clk);
        char_i = c;
        color_i = color;
        char_valid_i = 1'b1;
        guard = 0;
        while (!char_ready_o && guard < 100) begin
            @(negedge cpu_clk);
            guard++;
        end
        check("accept_in_time", 32'(guard < 100), 32'd1);
        @(posedge cpu_clk);
        #1;
        char_valid_i = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        do begin
            @(negedge cpu_clk);
            cycles++;
        end while (!(char_ready_o && !busy_o) && cycles < 4000);
        check("idle_in_time", 32'(cycles < 4000), 32'd1);
    endtask

    task automatic compare_writes(input string tag, input int base);
        int n;
        int f;
        n = act_q.size() - base;
        check({tag, "_nwrites"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            f = n_fail;
            check({tag, "_write"}, act_q[base + i], exp_q[i]);
            if (n_fail != f) break;
        end
    endtask

    task automatic do_char(input string tag, input logic [7:0] c, input logic color,
                           output int lat, output int wens);
        int base;
        int w0;
        exp_q.delete();
        model_char(c, color);
        base = act_q.size();
        w0 = wen_cycles;
        send_char(c, color);
        wait_idle(lat);
        wens = wen_cycles - w0;
        compare_writes(tag, base);
        check({tag, "_row"}, 32'(cursor_row_o), m_row);
        check({tag, "_col"}, 32'(cursor_col_o), m_col);
        $display("%s: char 0x%02h writes %0d cursor (%0d,%0d)", tag, c,
                 act_q.size() - base, cursor_row_o, cursor_col_o);
    endtask

    initial begin
        int lat;
        int wens;
        int base;
        int guard;
        logic [7:0] c;
        int r;

        rst = 1'b1;
        char_i = 8'h00;
        char_valid_i = 1'b0;
        color_i = 1'b0;
        repeat (3) @(negedge cpu_clk);

        // Reset state
        check("rst_ready", 32'(char_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_wen", 32'(vram_wen_o), 32'd0);
        check("rst_select", 32'(SELECT_txbl_o), 32'd0);
        check("rst_addr", 32'(vram_address_o), 32'h900);
        check("rst_wdata", 32'(vram_wdata_o), 32'h00);
        check("rst_row", 32'(cursor_row_o), 32'd0);
        check("rst_col", 32'(cursor_col_o), 32'd0);
        rst = 1'b0;
        @(negedge cpu_clk);
        check("ready_after_rst", 32'(char_ready_o), 32'd1);

        // 'A' with colorselect set, grant always high
        do_char("first_A", 8'h41, 1'b1, lat, wens);
        check("first_A_latency", lat, 32'd2);
        check("first_A_wencycles", wens, 32'd1);

        // Fill row 0 up to column 31
        for (int i = 0; i < 30; i++) do_char("fill_row0", 8'h61 + 8'(i % 26), 1'b0, lat, wens);

        // Last column write stalled for 5 cycles
        @(posedge cpu_clk);
        #1;
        stall_lo = ncyc + 2;
        stall_hi = ncyc + 7;
        do_char("stall_B", 8'h42, 1'b0, lat, wens);
        check("stall_B_wencycles", wens, 32'd6);

        // Walk down to (29,5), then LF wraps
        for (int i = 0; i < 28; i++) do_char("lf_walk", 8'h0A, 1'b0, lat, wens);
        for (int i = 0; i < 5; i++) do_char("row29", 8'h30 + 8'(i), 1'b1, lat, wens);
        do_char("lf_wrap", 8'h0A, 1'b0, lat, wens);

        // Backspace at column 0 and at column 4 of row 3
        for (int i = 0; i < 3; i++) do_char("lf_to3", 8'h0A, 1'b0, lat, wens);
        do_char("bs_col0", 8'h08, 1'b0, lat, wens);
        for (int i = 0; i < 4; i++) do_char("row3", 8'h58, 1'b0, lat, wens);
        do_char("bs_col4", 8'h08, 1'b0, lat, wens);
        do_char("cr", 8'h0D, 1'b0, lat, wens);
        do_char("other_code", 8'h7F, 1'b1, lat, wens);

        // Full clear (or ignored form feed), grant high
        do_char("ff_full", 8'h0C, 1'b0, lat, wens);

`ifdef TEXT_CONSOLE_CLEAR_EN
        // Reset after 100 clear writes aborts the clear
        do_char("pre_abort", 8'h5A, 1'b0, lat, wens);
        base = act_q.size();
        send_char(8'h0C, 1'b0);
        guard = 0;
        while (act_q.size() - base < 100 && guard < 2000) begin
            @(negedge cpu_clk);
            guard++;
        end
        rst = 1'b1;
        #1;
        check("abort_wen", 32'(vram_wen_o), 32'd0);
        check("abort_select", 32'(SELECT_txbl_o), 32'd0);
        check("abort_ready", 32'(char_ready_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_addr", 32'(vram_address_o), 32'h900);
        check("abort_row", 32'(cursor_row_o), 32'd0);
        check("abort_col", 32'(cursor_col_o), 32'd0);
        check("abort_nwrites", act_q.size() - base, 32'd100);
        for (int i = 0; i < 100 && base + i < act_q.size(); i++)
            check("abort_write", act_q[base + i], {12'(12'h900 + i), 8'h20});
        @(posedge cpu_clk);
        #1;
        check("abort_wen_held", 32'(vram_wen_o), 32'd0);
        @(negedge cpu_clk);
        rst = 1'b0;
        m_row = 0;
        m_col = 0;
        repeat (3) @(negedge cpu_clk);
        check("abort_no_more_writes", act_q.size() - base, 32'd100);
        check("abort_idle", 32'(char_ready_o), 32'd1);
        $display("abort: clear stopped after %0d writes", act_q.size() - base);
`endif

        // Randomized stream with random grants
        grant_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 8'($urandom_range(32, 126));
            else if (r < 74) c = 8'h0A;
            else if (r < 80) c = 8'h0D;
            else if (r < 90) c = 8'h08;
            else if (r < 91) c = 8'h0C;
            else             c = 8'($urandom_range(0, 255)) | 8'h80;
            do_char("rand", c, 1'($urandom_range(0, 1)), lat, wens);
        end

        check("select_tracks_wen", sel_bad, 32'd0);
        check("cursor_row_bound", bound_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
